loop_nest_sequencer: RTL and testbench

LOOP_NEST_SEQUENCER -- requirements
Module: loop_nest_sequencer

---
 rtl/loop_seq_pkg.sv | 4 +
 rtl/stride_counter.sv | 36 +++
 rtl/loop_nest_sequencer.sv | 83 ++++++++
 tb/tb_loop_nest_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared state encoding for the loop nest sequencer.
package loop_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
endpackage

// File: rtl/stride_counter.sv
// stride_counter: one loop index that steps from start to end, wrapping back to start.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i latches start/step/end
// and sets value to start; advance_i steps value (or wraps it when last);
// value_o current index; last_o high when one more step would pass the end.
module stride_counter #(
   parameter int Bits = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            advance_i,
   input  logic [Bits-1:0] start_i,
   input  logic [Bits-1:0] step_i,
   input  logic [Bits-1:0] end_i,
   output logic [Bits-1:0] value_o,
   output logic            last_o
);
   logic [Bits-1:0] start_q, step_q, end_q;
   // One extra bit keeps value+step from wrapping past the top of the range.
   assign last_o = ({1'b0, value_o} + {1'b0, step_q}) > {1'b0, end_q};
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q <= '0;
         step_q  <= '0;
         end_q   <= '0;
         value_o <= '0;
      end else if (load_i) begin
         start_q <= start_i;
         step_q  <= step_i;
         end_q   <= end_i;
         value_o <= start_i;
      end else if (advance_i) begin
         value_o <= last_o ? start_q : value_o + step_q;
      end
   end
endmodule

// File: rtl/loop_nest_sequencer.sv
// loop_nest_sequencer: emits every (outer, inner) index pair of a two-level strided loop nest.
// Ports: clk_i, rst_ni (async active-low); start_i launch in IDLE; inner_/outer_ start,end,step
// loop config; ready_i downstream accept; valid_o/outer_o/inner_o/last_o beat stream;
// busy_o (RUN or DONE), done_o (one-cycle end pulse), cfg_err_o (illegal config on done).
module loop_nest_sequencer
   import loop_seq_pkg::*;
#(
   parameter int Bits = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [Bits-1:0] inner_start_i,
   input  logic [Bits-1:0] inner_end_i,
   input  logic [Bits-1:0] inner_step_i,
   input  logic [Bits-1:0] outer_start_i,
   input  logic [Bits-1:0] outer_end_i,
   input  logic [Bits-1:0] outer_step_i,
   input  logic            ready_i,
   output logic            valid_o,
   output logic [Bits-1:0] outer_o,
   output logic [Bits-1:0] inner_o,
   output logic            last_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            cfg_err_o
);
   seq_state_e state_q, state_d;
   logic err_q, launch, legal, accept, inner_last, outer_last;
   assign launch = (state_q == IDLE) && start_i;
   assign legal  = (inner_end_i >= inner_start_i) && (outer_end_i >= outer_start_i) &&
                   (inner_step_i != '0) && (outer_step_i != '0);
   assign accept = (state_q == RUN) && ready_i;

   stride_counter #(.Bits(Bits)) u_inner (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (launch),
      .advance_i(accept),
      .start_i  (inner_start_i),
      .step_i   (inner_step_i),
      .end_i    (inner_end_i),
      .value_o  (inner_o),
      .last_o   (inner_last)
   );

   // Outer only moves when the inner row wraps, so the wrap costs no extra cycle.
   stride_counter #(.Bits(Bits)) u_outer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (launch),
      .advance_i(accept && inner_last),
      .start_i  (outer_start_i),
      .step_i   (outer_step_i),
      .end_i    (outer_end_i),
      .value_o  (outer_o),
      .last_o   (outer_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= launch ? !legal : err_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      valid_o   = state_q == RUN;
      busy_o    = state_q != IDLE;
      done_o    = state_q == DONE;
      cfg_err_o = (state_q == DONE) && err_q;
      last_o    = (state_q == RUN) && inner_last && outer_last;
      case (state_q)
         IDLE:    state_d = launch ? (legal ? RUN : DONE) : IDLE;
         RUN:     state_d = (accept && last_o) ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_loop_nest_sequencer.sv
// tb_loop_nest_sequencer: random and directed scans checked against a nested-loop reference model.
module tb_loop_nest_sequencer;
   localparam int B = 8;
   logic clk_i = 1'b0, rst_ni = 1'b1, start_i = 1'b0, ready_i = 1'b0;
   logic [B-1:0] inner_start_i = '0, inner_end_i = '0, inner_step_i = '0;
   logic [B-1:0] outer_start_i = '0, outer_end_i = '0, outer_step_i = '0;
   logic valid_o, last_o, busy_o, done_o, cfg_err_o;
   logic [B-1:0] outer_o, inner_o;
   int tests = 0, fails = 0;
   typedef struct {int o; int i; bit l;} beat_t;
   beat_t q[$];

   loop_nest_sequencer #(.Bits(B)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .inner_start_i(inner_start_i), .inner_end_i(inner_end_i), .inner_step_i(inner_step_i),
      .outer_start_i(outer_start_i), .outer_end_i(outer_end_i), .outer_step_i(outer_step_i),
      .ready_i(ready_i), .valid_o(valid_o), .outer_o(outer_o), .inner_o(inner_o),
      .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [20:0] obs();
      return {valid_o, busy_o, done_o, cfg_err_o, last_o, outer_o, inner_o};
   endfunction

   function automatic logic [4:0] status();
      return {valid_o, busy_o, done_o, cfg_err_o, last_o};
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
      end
   endtask

   // Reference: the loop nest written out as plain integer for-loops.
   task automatic build(input int is, ie, ist, os, oe, ost);
      q.delete();
      for (int o = os; o <= oe; o += ost)
         for (int i = is; i <= ie; i += ist)
            q.push_back('{o: o, i: i, l: (o + ost > oe) && (i + ist > ie)});
   endtask

   task automatic drive_cfg(input int is, ie, ist, os, oe, ost);
      inner_start_i = B'(is); inner_end_i = B'(ie); inner_step_i = B'(ist);
      outer_start_i = B'(os); outer_end_i = B'(oe); outer_step_i = B'(ost);
   endtask

   task automatic run(input int is, ie, ist, os, oe, ost, input int rdy_pct);
      int budget, cyc;
      bit r;
      build(is, ie, ist, os, oe, ost);
      budget = 20 * q.size() + 20;
      @(negedge clk_i);
      drive_cfg(is, ie, ist, os, oe, ost);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      drive_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      cyc = 0;
      while (q.size() > 0 && cyc < budget) begin
         chk("beat", 32'(obs()), 32'({1'b1, 1'b1, 1'b0, 1'b0, q[0].l, B'(q[0].o), B'(q[0].i)}));
         r = $urandom_range(99) < rdy_pct;
         ready_i = r;
         start_i = 1'($urandom_range(1));
         if (r) void'(q.pop_front());
         @(negedge clk_i);
         cyc++;
      end
      chk("scan_complete_beats_left", 32'(q.size()), 32'd0);
      chk("done_pulse", 32'(status()), 32'b01100);
      start_i = 1'b1;
      ready_i = 1'b0;
      @(negedge clk_i);
      chk("idle_after_done", 32'(status()), 32'b00000);
      start_i = 1'b0;
      @(negedge clk_i);
      chk("start_in_done_ignored", 32'(status()), 32'b00000);
   endtask

   task automatic bad(input int is, ie, ist, os, oe, ost);
      @(negedge clk_i);
      drive_cfg(is, ie, ist, os, oe, ost);
      start_i = 1'b1;
      ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("cfg_err_done", 32'(status()), 32'b01110);
      @(negedge clk_i);
      chk("cfg_err_idle", 32'(status()), 32'b00000);
   endtask

   initial begin
      int is, ie, ist, os, oe, ost;
      #1 rst_ni = 1'b0;
      #1 chk("reset_outputs", 32'(obs()), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("idle_after_reset", 32'(obs()), 32'd0);

      build(0, 3, 1, 0, 1, 1);
      chk("model_2x4_count", 32'(q.size()), 32'd8);
      chk("model_2x4_last", 32'(q[7].o * 100 + q[7].i * 10 + int'(q[7].l)), 32'd131);
      chk("model_2x4_not_last", 32'(q[6].l), 32'd0);
      build(2, 14, 3, 0, 1, 1);
      chk("model_step3_wrap", 32'(q[4].i * 100 + q[5].o * 10 + q[5].i), 32'd1412);
      build(0, 10, 4, 0, 0, 1);
      chk("model_step4_count", 32'(q.size()), 32'd3);
      build(0, 255, 16, 0, 0, 1);
      chk("model_top_count", 32'(q.size() * 1000 + q[15].i), 32'd16240);

      run(0, 3, 1, 0, 1, 1, 100);
      run(2, 14, 3, 0, 1, 1, 100);
      run(0, 10, 4, 3, 5, 2, 100);
      run(0, 255, 16, 0, 1, 1, 100);
      run(7, 7, 1, 9, 9, 5, 100);
      run(0, 3, 1, 0, 1, 1, 50);
      run(0, 3, 1, 0, 1, 1, 30);

      bad(0, 3, 0, 0, 1, 1);
      bad(0, 3, 1, 0, 1, 0);
      bad(5, 3, 1, 0, 1, 1);
      bad(0, 3, 1, 4, 1, 1);

      for (int k = 0; k < 20; k++) begin
         is  = int'($urandom_range(0, 250));
         ie  = is + int'($urandom_range(0, (255 - is) < 30 ? 255 - is : 30));
         ist = int'($urandom_range(1, 7));
         os  = int'($urandom_range(0, 250));
         oe  = os + int'($urandom_range(0, (255 - os) < 8 ? 255 - os : 8));
         ost = int'($urandom_range(1, 4));
         build(is, ie, ist, os, oe, ost);
         chk("model_formula", 32'(q.size()), 32'(((ie - is) / ist + 1) * ((oe - os) / ost + 1)));
         run(is, ie, ist, os, oe, ost, int'($urandom_range(30, 100)));
      end

      @(negedge clk_i);
      drive_cfg(0, 3, 1, 0, 1, 1);
      start_i = 1'b1;
      ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("pre_reset_beat", 32'(obs()), 32'({5'b11000, 8'd0, 8'd3}));
      #2 rst_ni = 1'b0;
      #1 chk("async_reset_outputs", 32'(obs()), 32'd0);
      @(negedge clk_i);
      chk("held_reset_outputs", 32'(obs()), 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("idle_after_mid_reset", 32'(status()), 32'b00000);
      @(negedge clk_i);
      chk("no_done_after_mid_reset", 32'(status()), 32'b00000);
      run(0, 3, 1, 0, 1, 1, 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
